// File: rtl/pulse_pacer_pkg.sv
// Shared types and constants for the pulse pacer.
// Holds the FSM state encoding, GAP limits and the gap-timer width helper.
package pulse_pacer_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_e;

    localparam int unsigned GAP_MIN = 2;
    localparam int unsigned GAP_MAX = 255;

    function automatic int unsigned gcnt_w(input int unsigned gap);
        return (gap <= 2) ? 1 : $clog2(gap);
    endfunction

endpackage

// File: rtl/pulse_pacer_cnt.sv
// Saturating up/down counter with synchronous clear.
// sat_drop flags an increment that was lost because the count was full.
module pulse_pacer_cnt
    import pulse_pacer_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         dec,
    input  logic         clr,
    output logic [W-1:0] count,
    output logic         sat_drop
);

    localparam logic [W-1:0] CMAX = '1;

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;
    logic         up;
    logic         down;

    assign up   = !clr && inc && !dec;
    assign down = !clr && dec && !inc;

    always_comb begin
        cnt_d    = cnt_q;
        sat_drop = 1'b0;
        unique case (1'b1)
            clr: begin
                cnt_d = '0;
            end
            up: begin
                if (cnt_q == CMAX) begin
                    sat_drop = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            down: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                cnt_d = cnt_q;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count = cnt_q;

endmodule

// File: rtl/pulse_pacer.sv
// Paces bursty source events into isolated pulses at least GAP cycles apart.
// Define PULSE_PACER_ACK_EN to end the gap early on a far-domain ack.
module pulse_pacer
    import pulse_pacer_pkg::*;
#(
    parameter int unsigned GAP   = 8,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ev,
    input  logic             clr,
    output logic             pls,
    output logic [CNT_W-1:0] pend,
    output logic             busy,
    output logic             ovf
`ifdef PULSE_PACER_ACK_EN
    ,
    input  logic             ack,
    output logic             tmo
`endif
);

    localparam int unsigned GW = gcnt_w(GAP);
    localparam logic [GW-1:0] GRELOAD = GW'(GAP - 1);

    if (GAP < GAP_MIN || GAP > GAP_MAX) begin : g_gap_chk
        $error("pulse_pacer: GAP out of range");
    end

    state_e        state_q;
    logic [GW-1:0] gcnt_q;
    logic          pls_q;
    logic          ovf_q;
    logic          issue;
    logic          ack_hit;
    logic          sat_drop;
    logic          gap_done;

`ifdef PULSE_PACER_ACK_EN
    logic tmo_q;
    assign ack_hit = (state_q == WAIT) && ack;
    assign tmo     = tmo_q;
`else
    assign ack_hit = 1'b0;
`endif

    assign gap_done = (gcnt_q == '0) || ack_hit;

    // A clear empties the backlog, so it also suppresses this cycle's issue.
    always_comb begin
        issue = 1'b0;
        if (!clr && pend != '0) begin
            unique case (state_q)
                IDLE:    issue = 1'b1;
                WAIT:    issue = gap_done;
                default: issue = 1'b0;
            endcase
        end
    end

    pulse_pacer_cnt #(
        .W (CNT_W)
    ) u_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .inc      (ev),
        .dec      (issue),
        .clr      (clr),
        .count    (pend),
        .sat_drop (sat_drop)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gcnt_q  <= '0;
            pls_q   <= 1'b0;
            ovf_q   <= 1'b0;
`ifdef PULSE_PACER_ACK_EN
            tmo_q   <= 1'b0;
`endif
        end else begin
            pls_q <= issue;
            if (clr) begin
                ovf_q <= 1'b0;
            end else if (sat_drop) begin
                ovf_q <= 1'b1;
            end
`ifdef PULSE_PACER_ACK_EN
            if (clr) begin
                tmo_q <= 1'b0;
            end else if (state_q == WAIT && gcnt_q == '0 && !ack) begin
                tmo_q <= 1'b1;
            end
`endif
            unique case (state_q)
                IDLE: begin
                    if (issue) begin
                        state_q <= WAIT;
                        gcnt_q  <= GRELOAD;
                    end
                end
                WAIT: begin
                    if (issue) begin
                        gcnt_q <= GRELOAD;
                    end else if (gap_done) begin
                        state_q <= IDLE;
                    end else begin
                        gcnt_q <= gcnt_q - 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign pls  = pls_q;
    assign ovf  = ovf_q;
    assign busy = (state_q != IDLE) || (pend != '0);

endmodule
